// File: rtl/demux_dispatch.sv
// ---------------------------------------------------------------------------
// demux_dispatch
// Upstream feeder for the 16-bit 1-to-3 demultiplexer. Words arrive over a
// valid/ready handshake, are buffered in a DEPTH-word FIFO and dispatched
// round-robin to whichever of three destination channels is ready. The demux
// data (x) and select (s) are registered; s=2'b11 marks an idle cycle.
//
// Optional feature: define DEMUX_DISPATCH_CNT_EN to add the per-channel
// dispatch counters cnt0/cnt1/cnt2 (16-bit, wrapping).
// ---------------------------------------------------------------------------
module demux_dispatch #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [W-1:0]             in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               dst_ready,
    output logic [W-1:0]             x,
    output logic [1:0]               s,
    output logic [$clog2(DEPTH):0]   fifo_count
`ifdef DEMUX_DISPATCH_CNT_EN
    ,
    output logic [15:0]              cnt0,
    output logic [15:0]              cnt1,
    output logic [15:0]              cnt2
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [1:0] S_IDLE = 2'b11;

    // Round-robin pointer: the channel the next search starts from.
    typedef enum logic [1:0] {
        CH0 = 2'd0,
        CH1 = 2'd1,
        CH2 = 2'd2
    } rr_e;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    rr_e           rr_q, rr_d;
    logic [W-1:0]  x_q, x_d;
    logic [1:0]    s_q, s_d;

    logic          full_s;
    logic          empty_s;
    logic          push_s;
    logic          pop_s;
    logic          found_s;
    logic [1:0]    sel_s;
    logic [W-1:0]  head_s;

    // Ready depends on stored occupancy only; a same-cycle pop never frees
    // a slot for a push. Held low while reset is asserted.
    assign full_s     = (count_q == CW'(DEPTH));
    assign empty_s    = (count_q == {CW{1'b0}});
    assign in_ready   = ~full_s & ~rst;
    assign push_s     = in_valid & in_ready;
    assign head_s     = mem_q[rd_ptr_q];
    assign pop_s      = found_s;

    assign x          = x_q;
    assign s          = s_q;
    assign fifo_count = count_q;

    // Cyclic search for the first ready channel starting at the RR pointer.
    always_comb begin
        found_s = 1'b0;
        sel_s   = 2'd0;
        if (!empty_s) begin
            case (rr_q)
                CH0: begin
                    if (dst_ready[0])      begin found_s = 1'b1; sel_s = 2'd0; end
                    else if (dst_ready[1]) begin found_s = 1'b1; sel_s = 2'd1; end
                    else if (dst_ready[2]) begin found_s = 1'b1; sel_s = 2'd2; end
                    else                   begin found_s = 1'b0; sel_s = 2'd0; end
                end
                CH1: begin
                    if (dst_ready[1])      begin found_s = 1'b1; sel_s = 2'd1; end
                    else if (dst_ready[2]) begin found_s = 1'b1; sel_s = 2'd2; end
                    else if (dst_ready[0]) begin found_s = 1'b1; sel_s = 2'd0; end
                    else                   begin found_s = 1'b0; sel_s = 2'd0; end
                end
                CH2: begin
                    if (dst_ready[2])      begin found_s = 1'b1; sel_s = 2'd2; end
                    else if (dst_ready[0]) begin found_s = 1'b1; sel_s = 2'd0; end
                    else if (dst_ready[1]) begin found_s = 1'b1; sel_s = 2'd1; end
                    else                   begin found_s = 1'b0; sel_s = 2'd0; end
                end
                default: begin
                    found_s = 1'b0;
                    sel_s   = 2'd0;
                end
            endcase
        end else begin
            found_s = 1'b0;
            sel_s   = 2'd0;
        end
    end

    // Next state for FIFO storage/pointers, occupancy, RR pointer and outputs.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        rr_d     = rr_q;
        x_d      = {W{1'b0}};
        s_d      = S_IDLE;

        if (push_s) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d        = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            x_d      = head_s;
            s_d      = sel_s;
            case (sel_s)
                2'd0:    rr_d = CH1;
                2'd1:    rr_d = CH2;
                2'd2:    rr_d = CH0;
                default: rr_d = CH0;
            endcase
        end else begin
            rd_ptr_d = rd_ptr_q;
            rr_d     = rr_q;
        end

        count_d = count_q + CW'(push_s) - CW'(pop_s);
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Control and output registers; reset flushes the FIFO and idles the demux.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            rr_q     <= CH0;
            x_q      <= {W{1'b0}};
            s_q      <= S_IDLE;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rr_q     <= rr_d;
            x_q      <= x_d;
            s_q      <= s_d;
        end
    end

`ifdef DEMUX_DISPATCH_CNT_EN
    logic [15:0] cnt0_q, cnt0_d;
    logic [15:0] cnt1_q, cnt1_d;
    logic [15:0] cnt2_q, cnt2_d;

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
    assign cnt2 = cnt2_q;

    // Bump the counter of the channel receiving a word; wraps naturally.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        cnt2_d = cnt2_q;
        if (pop_s) begin
            case (sel_s)
                2'd0:    cnt0_d = cnt0_q + 16'd1;
                2'd1:    cnt1_d = cnt1_q + 16'd1;
                2'd2:    cnt2_d = cnt2_q + 16'd1;
                default: cnt0_d = cnt0_q;
            endcase
        end else begin
            cnt0_d = cnt0_q;
        end
    end

    // Dispatch counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0_q <= 16'd0;
            cnt1_q <= 16'd0;
            cnt2_q <= 16'd0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
            cnt2_q <= cnt2_d;
        end
    end
`endif

endmodule

// File: tb/tb_demux_dispatch.sv
// ---------------------------------------------------------------------------
// tb_demux_dispatch
// Self-checking bench for demux_dispatch: a hand-computed vector table,
// directed multi-cycle sequences and a randomized run, all cross-checked
// against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_demux_dispatch;

    localparam int DEPTH = 4;
    localparam int W     = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [W-1:0]   in_data = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [2:0]     dst_ready = 3'b000;
    logic [W-1:0]   x;
    logic [1:0]     s;
    logic [CW-1:0]  fifo_count;
`ifdef DEMUX_DISPATCH_CNT_EN
    logic [15:0]    cnt0, cnt1, cnt2;
`endif

    always #5 clk = ~clk;

    demux_dispatch #(.DEPTH(DEPTH), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dst_ready  (dst_ready),
        .x          (x),
        .s          (s),
        .fifo_count (fifo_count)
`ifdef DEMUX_DISPATCH_CNT_EN
        ,
        .cnt0       (cnt0),
        .cnt1       (cnt1),
        .cnt2       (cnt2)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: FIFO as a queue, pointer as a channel number.
    logic [W-1:0] mq[$];
    int           m_ptr;
    int           m_cnt[3];
    logic [W-1:0] m_x;
    logic [1:0]   m_s;
    bit           last_pushed;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_ptr = 0;
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;
        m_x = '0;
        m_s = 2'b11;
    endtask

    // One clock cycle: drive inputs, check ready, clock, advance model, compare.
    task automatic step(input logic v, input logic [W-1:0] d, input logic [2:0] dr);
        bit exp_rdy;
        bit found;
        int c;
        in_valid  = v;
        in_data   = d;
        dst_ready = dr;
        #1;
        exp_rdy = (mq.size() < DEPTH);
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        @(posedge clk);
        found = 1'b0;
        c = 0;
        if (mq.size() > 0) begin
            for (int i = 0; i < 3; i++) begin
                if (!found && dr[(m_ptr + i) % 3]) begin
                    found = 1'b1;
                    c = (m_ptr + i) % 3;
                end
            end
        end
        if (found) begin
            m_x = mq.pop_front();
            m_s = 2'(c);
            m_ptr = (c + 1) % 3;
            m_cnt[c] = (m_cnt[c] + 1) % 65536;
        end else begin
            m_x = '0;
            m_s = 2'b11;
        end
        last_pushed = v && exp_rdy;
        if (last_pushed) mq.push_back(d);
        #1;
        chk("x", 32'(x), 32'(m_x));
        chk("s", 32'(s), 32'(m_s));
        chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
`ifdef DEMUX_DISPATCH_CNT_EN
        chk("cnt0", 32'(cnt0), 32'(m_cnt[0]));
        chk("cnt1", 32'(cnt1), 32'(m_cnt[1]));
        chk("cnt2", 32'(cnt2), 32'(m_cnt[2]));
`endif
    endtask

    // Assert reset asynchronously, check immediate idle, release between edges.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_x", 32'(x), 32'd0);
        chk("rst_s", 32'(s), 32'd3);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
`ifdef DEMUX_DISPATCH_CNT_EN
        chk("rst_cnt", {cnt0, cnt1}, 32'd0);
        chk("rst_cnt2", 32'(cnt2), 32'd0);
`endif
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic         v;
        logic [15:0]  d;
        logic [2:0]   dr;
        logic [15:0]  ex;
        logic [1:0]   es;
        int           ecnt;
    } vec_t;

    vec_t tbl[12];

    initial begin : main
        logic [15:0] w3[6];
        logic [1:0]  sseq[6];
        logic [15:0] xseq[6];
        logic [1:0]  es3[4];
        logic [1:0]  es6[5];
        int          k;
        int          nd;
        int          cyc;
        logic [15:0] pend;
        bit          have;
        logic [2:0]  rdr;

        model_clear();
        #2;
        do_reset();

        // Tests 1, 2 and pointer wrap: hand-computed expectations.
        tbl[0]  = '{1'b1, 16'hA001, 3'b111, 16'h0000, 2'b11, 1};
        tbl[1]  = '{1'b1, 16'hA002, 3'b111, 16'hA001, 2'b00, 1};
        tbl[2]  = '{1'b1, 16'hA003, 3'b111, 16'hA002, 2'b01, 1};
        tbl[3]  = '{1'b1, 16'hA004, 3'b111, 16'hA003, 2'b10, 1};
        tbl[4]  = '{1'b0, 16'h0000, 3'b111, 16'hA004, 2'b00, 0};
        tbl[5]  = '{1'b0, 16'h0000, 3'b111, 16'h0000, 2'b11, 0};
        tbl[6]  = '{1'b1, 16'h1111, 3'b010, 16'h0000, 2'b11, 1};
        tbl[7]  = '{1'b1, 16'h2222, 3'b010, 16'h1111, 2'b01, 1};
        tbl[8]  = '{1'b0, 16'h0000, 3'b010, 16'h2222, 2'b01, 0};
        tbl[9]  = '{1'b0, 16'h0000, 3'b100, 16'h0000, 2'b11, 0};
        tbl[10] = '{1'b1, 16'h3333, 3'b111, 16'h0000, 2'b11, 1};
        tbl[11] = '{1'b0, 16'h0000, 3'b111, 16'h3333, 2'b10, 0};
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].dr);
            chk($sformatf("tbl%0d_x", i), 32'(x), 32'(tbl[i].ex));
            chk($sformatf("tbl%0d_s", i), 32'(s), 32'(tbl[i].es));
            chk($sformatf("tbl%0d_cnt", i), 32'(fifo_count), 32'(tbl[i].ecnt));
        end

        // Test 3: fill with no consumer ready, then drain.
        w3 = '{16'h3001, 16'h3002, 16'h3003, 16'h3004, 16'h3005, 16'h3006};
        es3 = '{2'b00, 2'b01, 2'b10, 2'b00};
        k = 0;
        cyc = 0;
        while (k < 4 && cyc < 20) begin
            step(1'b1, w3[k], 3'b000);
            if (last_pushed) k++;
            cyc++;
        end
        chk("t3_full_count", 32'(fifo_count), 32'd4);
        chk("t3_full_ready", {31'd0, in_ready}, 32'd0);
        step(1'b1, w3[4], 3'b000);
        step(1'b1, w3[4], 3'b000);
        chk("t3_hold_count", 32'(fifo_count), 32'd4);
        nd = 0;
        cyc = 0;
        while (nd < 6 && cyc < 40) begin
            step(k < 6, (k < 6) ? w3[k] : 16'h0000, 3'b111);
            if (last_pushed) k++;
            if (s != 2'b11) begin
                sseq[nd] = s;
                xseq[nd] = x;
                nd++;
            end
            cyc++;
        end
        chk("t3_drained", 32'(nd), 32'd6);
        for (int i = 0; i < nd; i++) chk($sformatf("t3_order%0d", i), 32'(xseq[i]), 32'(w3[i]));
        for (int i = 0; i < 4 && i < nd; i++) chk($sformatf("t3_sel%0d", i), 32'(sseq[i]), 32'(es3[i]));

        // Test 4: two buffered, push and pop together.
        step(1'b1, 16'h4001, 3'b000);
        step(1'b1, 16'h4002, 3'b000);
        chk("t4_pre_count", 32'(fifo_count), 32'd2);
        step(1'b1, 16'h4003, 3'b111);
        chk("t4_count", 32'(fifo_count), 32'd2);
        chk("t4_x0", 32'(x), 32'h4001);
        step(1'b0, 16'h0000, 3'b111);
        chk("t4_x1", 32'(x), 32'h4002);
        step(1'b0, 16'h0000, 3'b111);
        chk("t4_x2", 32'(x), 32'h4003);
        step(1'b0, 16'h0000, 3'b111);

        // Test 5: reset with words buffered.
        step(1'b1, 16'h5001, 3'b000);
        step(1'b1, 16'h5002, 3'b000);
        step(1'b1, 16'h5003, 3'b000);
        chk("t5_pre_count", 32'(fifo_count), 32'd3);
        do_reset();
        step(1'b1, 16'h5A5A, 3'b111);
        step(1'b0, 16'h0000, 3'b111);
        chk("t5_s", 32'(s), 32'd0);
        chk("t5_x", 32'(x), 32'h5A5A);
        step(1'b0, 16'h0000, 3'b111);

        // Test 6: channels 0 and 2 ready, five words.
        do_reset();
        es6 = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b00};
        nd = 0;
        k = 0;
        cyc = 0;
        while (nd < 5 && cyc < 30) begin
            step(k < 5, 16'h6000 + 16'(k), 3'b101);
            if (last_pushed) k++;
            if (s != 2'b11) begin
                sseq[nd] = s;
                nd++;
            end
            cyc++;
        end
        chk("t6_done", 32'(nd), 32'd5);
        for (int i = 0; i < nd; i++) chk($sformatf("t6_sel%0d", i), 32'(sseq[i]), 32'(es6[i]));
`ifdef DEMUX_DISPATCH_CNT_EN
        chk("t6_cnt0", 32'(cnt0), 32'd3);
        chk("t6_cnt1", 32'(cnt1), 32'd0);
        chk("t6_cnt2", 32'(cnt2), 32'd2);
`endif

        // Randomized traffic against the model; upstream holds until accepted.
        have = 1'b0;
        pend = '0;
        for (int n = 0; n < 400; n++) begin
            if (!have) begin
                have = ($urandom_range(0, 3) != 0);
                pend = 16'($urandom);
            end
            rdr = ($urandom_range(0, 4) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
            step(have, pend, rdr);
            if (last_pushed) have = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_dispatch.md
Name: demux_dispatch

Overview:
Upstream feeder for the 16-bit 1-to-3 demultiplexer. It accepts a stream of 16-bit words over a valid/ready handshake and buffers them in a small FIFO. Each word is dispatched round-robin to whichever of three destination channels is ready. It drives the demux data (x) and select (s) from registers, and holds s=2'b11 (all demux outputs zero) whenever nothing is dispatched.

Parameters:
DEPTH, 4, FIFO depth in words; must be a power of two, minimum 2.
W, 16, data width; must match the demux data width.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
in_data  input  W  upstream word
in_valid  input  1  upstream word valid
in_ready  output  1  block can accept a word this cycle
dst_ready  input  3  per-channel consumer ready; bit0=ch0 (s=00), bit1=ch1 (s=01), bit2=ch2 (s=10)
x  output  W  data to demux
s  output  2  select to demux; 2'b11 = idle
fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, active-high), while rst is high:
  - x=0, s=2'b11, fifo_count=0, FIFO flushed, RR pointer=CH0.
  - in_ready is 0 while rst is high, then 1 from the first cycle after release.
- Reset mid-operation: buffered words are discarded with no partial dispatch, and any x/s in flight is forced to idle immediately.
- Push:
  - in_ready = !full. It is combinational from occupancy only; a same-cycle pop does not free a slot for a push.
  - A push occurs on a clock edge when in_valid && in_ready.
- RR pointer: 3-state machine CH0 -> CH1 -> CH2 -> CH0.
- Dispatch decision, each cycle:
  - If the FIFO is non-empty, search channels starting at the RR pointer in cyclic order and select the first one whose dst_ready bit is 1.
  - If a channel c is found: pop the FIFO head, register x=head and s=c, and set the pointer to (c+1) mod 3.
  - If no channel is ready or the FIFO is empty: register x=0 and s=2'b11, and leave the pointer unchanged.
- Output hold rule: x and s are valid for exactly one cycle per dispatched word. Consecutive words may dispatch on back-to-back cycles.
- Latency: a word pushed on edge N appears on x/s no earlier than after edge N+1 (1 cycle through an empty FIFO).
- Order: FIFO order is preserved. Words are never reordered or dropped.
- Simultaneous push and pop (not full): occupancy is unchanged and both operations take effect.
- Full: in_ready=0, and upstream must hold in_data/in_valid. Empty with in_valid: the push occurs, with no dispatch that cycle.
- Pointer wrap: after dispatching to CH2, the search starts at CH0.
- dst_ready=3'b000 with FIFO non-empty: idle output, and the FIFO keeps filling until full.
- dst_ready is sampled in the same cycle the decision is made. A consumer dropping ready only affects later decisions.

Optional Feature:
- Macro: DEMUX_DISPATCH_CNT_EN.
- When defined:
  - Adds three output ports cnt0, cnt1, cnt2 (16 bits each) counting words dispatched per channel.
  - Each counter increments on the edge where its channel is dispatched and wraps from 16'hFFFF to 0.
  - All counters reset to 0 with rst.
- When undefined: the ports and counter logic are absent, and all other behaviour is identical.

Test Plan:
1. Reset release, dst_ready=3'b111, push 16'hA001, 16'hA002, 16'hA003, 16'hA004 on consecutive cycles -> x/s = A001/00, A002/01, A003/10, A004/00, starting 1 cycle after the first push; then s=11, x=0.
2. dst_ready=3'b010, push 16'h1111, 16'h2222 -> both dispatched with s=01, in order, on consecutive cycles; the pointer ends at CH2.
3. dst_ready=3'b000, push 6 words with DEPTH=4 -> in_ready falls after the 4th push and fifo_count=4. Raise dst_ready=3'b111 -> the four words leave with s=00, 01, 10, 00, then the remaining two are accepted and dispatched.
4. FIFO at 2 words, push and dispatch in the same cycle -> fifo_count stays 2 and the order is preserved.
5. Assert rst mid-stream with 3 words buffered -> x=0, s=11, fifo_count=0 immediately; after release the first new word dispatches to s=00.
6. With DEMUX_DISPATCH_CNT_EN and dst_ready=3'b101, push 5 words -> s sequence 00, 10, 00, 10, 00; cnt0=3, cnt1=0, cnt2=2.
